// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register.
// Captures the decode-stage bundle and presents it to EX one cycle later.
// Freeze holds the current contents. Flush inserts a fully zeroed bubble, and it
// takes priority over freeze. Saturating counters track bubbles and flushes.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   flush, freeze          kill incoming instruction / hold current contents
//   id_valid               ID bundle holds a real instruction
//   *_in / *_out           decode bundle fields and their registered copies
//   valid_out              EX holds a real instruction
//   bubble_cnt, flush_cnt  saturating debug event counters
module id_ex_stage_reg #(
  parameter int unsigned WORD_WIDTH            = 32,
  parameter int unsigned REG_FILE_DEPTH        = 4,
  parameter int unsigned SIGNED_IMM_WIDTH      = 24,
  parameter int unsigned SHIFTER_OPERAND_WIDTH = 12,
  parameter int unsigned CNT_WIDTH             = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             freeze,
  input  logic                             id_valid,
  input  logic [WORD_WIDTH-1:0]            pc_in,
  input  logic [REG_FILE_DEPTH-1:0]        reg_file_dst_in,
  input  logic [REG_FILE_DEPTH-1:0]        src1_in,
  input  logic [REG_FILE_DEPTH-1:0]        src2_in,
  input  logic [WORD_WIDTH-1:0]            val_rn_in,
  input  logic [WORD_WIDTH-1:0]            val_rm_in,
  input  logic [SIGNED_IMM_WIDTH-1:0]      signed_imm_in,
  input  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_in,
  input  logic [3:0]                       status_in,
  input  logic [3:0]                       ex_cmd_in,
  input  logic                             mem_read_in,
  input  logic                             mem_write_in,
  input  logic                             wb_en_in,
  input  logic                             imm_in,
  input  logic                             b_in,
  input  logic                             update_in,
  output logic [WORD_WIDTH-1:0]            pc_out,
  output logic [REG_FILE_DEPTH-1:0]        reg_file_dst_out,
  output logic [REG_FILE_DEPTH-1:0]        src1_out,
  output logic [REG_FILE_DEPTH-1:0]        src2_out,
  output logic [WORD_WIDTH-1:0]            val_rn_out,
  output logic [WORD_WIDTH-1:0]            val_rm_out,
  output logic [SIGNED_IMM_WIDTH-1:0]      signed_imm_out,
  output logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_out,
  output logic [3:0]                       status_out,
  output logic [3:0]                       ex_cmd_out,
  output logic                             mem_read_out,
  output logic                             mem_write_out,
  output logic                             wb_en_out,
  output logic                             imm_out,
  output logic                             b_out,
  output logic                             update_out,
  output logic                             valid_out,
  output logic [CNT_WIDTH-1:0]             bubble_cnt,
  output logic [CNT_WIDTH-1:0]             flush_cnt
);

  logic [WORD_WIDTH-1:0]            pc_q, val_rn_q, val_rm_q;
  logic [REG_FILE_DEPTH-1:0]        dst_q, src1_q, src2_q;
  logic [SIGNED_IMM_WIDTH-1:0]      signed_imm_q;
  logic [SHIFTER_OPERAND_WIDTH-1:0] shifter_operand_q;
  logic [3:0]                       status_q, ex_cmd_q;
  logic                             mem_read_q, mem_write_q, wb_en_q, imm_q, b_q, update_q;
  logic                             valid_q;
  logic [CNT_WIDTH-1:0]             bubble_cnt_q, bubble_cnt_d;
  logic [CNT_WIDTH-1:0]             flush_cnt_q, flush_cnt_d;

  // Flush always counts as a bubble too; a frozen, non-flushed edge counts nothing.
  logic bubble_event, flush_event;

  always_comb begin
    flush_event  = flush;
    bubble_event = flush || (!freeze && !id_valid);
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (bubble_event && (bubble_cnt_q != {CNT_WIDTH{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
    if (flush_event && (flush_cnt_q != {CNT_WIDTH{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q              <= '0;
      dst_q             <= '0;
      src1_q            <= '0;
      src2_q            <= '0;
      val_rn_q          <= '0;
      val_rm_q          <= '0;
      signed_imm_q      <= '0;
      shifter_operand_q <= '0;
      status_q          <= '0;
      ex_cmd_q          <= '0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      wb_en_q           <= 1'b0;
      imm_q             <= 1'b0;
      b_q               <= 1'b0;
      update_q          <= 1'b0;
      valid_q           <= 1'b0;
      bubble_cnt_q      <= '0;
      flush_cnt_q       <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      if (flush) begin
        pc_q              <= '0;
        dst_q             <= '0;
        src1_q            <= '0;
        src2_q            <= '0;
        val_rn_q          <= '0;
        val_rm_q          <= '0;
        signed_imm_q      <= '0;
        shifter_operand_q <= '0;
        status_q          <= '0;
        ex_cmd_q          <= '0;
        mem_read_q        <= 1'b0;
        mem_write_q       <= 1'b0;
        wb_en_q           <= 1'b0;
        imm_q             <= 1'b0;
        b_q               <= 1'b0;
        update_q          <= 1'b0;
        valid_q           <= 1'b0;
      end else if (!freeze) begin
        // Data fields load even for a bubble; only control is gated by id_valid.
        pc_q              <= pc_in;
        dst_q             <= reg_file_dst_in;
        src1_q            <= src1_in;
        src2_q            <= src2_in;
        val_rn_q          <= val_rn_in;
        val_rm_q          <= val_rm_in;
        signed_imm_q      <= signed_imm_in;
        shifter_operand_q <= shifter_operand_in;
        status_q          <= status_in;
        ex_cmd_q          <= id_valid ? ex_cmd_in : 4'b0;
        mem_read_q        <= id_valid & mem_read_in;
        mem_write_q       <= id_valid & mem_write_in;
        wb_en_q           <= id_valid & wb_en_in;
        imm_q             <= id_valid & imm_in;
        b_q               <= id_valid & b_in;
        update_q          <= id_valid & update_in;
        valid_q           <= id_valid;
      end
    end
  end

  assign pc_out              = pc_q;
  assign reg_file_dst_out    = dst_q;
  assign src1_out            = src1_q;
  assign src2_out            = src2_q;
  assign val_rn_out          = val_rn_q;
  assign val_rm_out          = val_rm_q;
  assign signed_imm_out      = signed_imm_q;
  assign shifter_operand_out = shifter_operand_q;
  assign status_out          = status_q;
  assign ex_cmd_out          = ex_cmd_q;
  assign mem_read_out        = mem_read_q;
  assign mem_write_out       = mem_write_q;
  assign wb_en_out           = wb_en_q;
  assign imm_out             = imm_q;
  assign b_out               = b_q;
  assign update_out          = update_q;
  assign valid_out           = valid_q;
  assign bubble_cnt          = bubble_cnt_q;
  assign flush_cnt           = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios plus randomized
// traffic, compared against a bundle-level reference model.
module tb_id_ex_stage_reg;

  localparam int unsigned CntMax = 15;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [31:0] rn;
    logic [31:0] rm;
    logic [23:0] simm;
    logic [11:0] shop;
    logic [3:0]  status;
    logic [3:0]  cmd;
    logic        mem_read;
    logic        mem_write;
    logic        wb_en;
    logic        imm;
    logic        b;
    logic        update;
  } bundle_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    flush = 1'b0;
  logic    freeze = 1'b0;
  logic    id_valid = 1'b0;
  bundle_t in_b = '0;

  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0]  reg_file_dst_out, src1_out, src2_out, status_out, ex_cmd_out;
  logic [23:0] signed_imm_out;
  logic [11:0] shifter_operand_out;
  logic        mem_read_out, mem_write_out, wb_en_out, imm_out, b_out, update_out, valid_out;
  logic [3:0]  bubble_cnt, flush_cnt;

  // Reference model state.
  bundle_t     exp_b;
  logic        exp_valid;
  int unsigned exp_bub, exp_fl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(
    .WORD_WIDTH(32), .REG_FILE_DEPTH(4), .SIGNED_IMM_WIDTH(24),
    .SHIFTER_OPERAND_WIDTH(12), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .id_valid(id_valid),
    .pc_in(in_b.pc), .reg_file_dst_in(in_b.dst), .src1_in(in_b.src1), .src2_in(in_b.src2),
    .val_rn_in(in_b.rn), .val_rm_in(in_b.rm), .signed_imm_in(in_b.simm),
    .shifter_operand_in(in_b.shop), .status_in(in_b.status), .ex_cmd_in(in_b.cmd),
    .mem_read_in(in_b.mem_read), .mem_write_in(in_b.mem_write), .wb_en_in(in_b.wb_en),
    .imm_in(in_b.imm), .b_in(in_b.b), .update_in(in_b.update),
    .pc_out(pc_out), .reg_file_dst_out(reg_file_dst_out), .src1_out(src1_out),
    .src2_out(src2_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .signed_imm_out(signed_imm_out), .shifter_operand_out(shifter_operand_out),
    .status_out(status_out), .ex_cmd_out(ex_cmd_out), .mem_read_out(mem_read_out),
    .mem_write_out(mem_write_out), .wb_en_out(wb_en_out), .imm_out(imm_out), .b_out(b_out),
    .update_out(update_out), .valid_out(valid_out), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},     64'(pc_out),              64'(exp_b.pc));
    check({tag, ".dst"},    64'(reg_file_dst_out),    64'(exp_b.dst));
    check({tag, ".src1"},   64'(src1_out),            64'(exp_b.src1));
    check({tag, ".src2"},   64'(src2_out),            64'(exp_b.src2));
    check({tag, ".rn"},     64'(val_rn_out),          64'(exp_b.rn));
    check({tag, ".rm"},     64'(val_rm_out),          64'(exp_b.rm));
    check({tag, ".simm"},   64'(signed_imm_out),      64'(exp_b.simm));
    check({tag, ".shop"},   64'(shifter_operand_out), 64'(exp_b.shop));
    check({tag, ".status"}, 64'(status_out),          64'(exp_b.status));
    check({tag, ".ctrl"},
          64'({ex_cmd_out, mem_read_out, mem_write_out, wb_en_out, imm_out, b_out, update_out}),
          64'({exp_b.cmd, exp_b.mem_read, exp_b.mem_write, exp_b.wb_en, exp_b.imm, exp_b.b,
               exp_b.update}));
    check({tag, ".valid"},  64'(valid_out),           64'(exp_valid));
    check({tag, ".bub"},    64'(bubble_cnt),          64'(exp_bub));
    check({tag, ".fl"},     64'(flush_cnt),           64'(exp_fl));
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CntMax) ? CntMax : v + 1;
  endfunction

  task automatic model_reset();
    exp_b = '0;
    exp_valid = 1'b0;
    exp_bub = 0;
    exp_fl = 0;
  endtask

  // Apply the edge rules to the inputs as they stand before the edge.
  task automatic model_edge();
    bundle_t t;
    if (flush) begin
      exp_b = '0;
      exp_valid = 1'b0;
      exp_fl = sat_inc(exp_fl);
      exp_bub = sat_inc(exp_bub);
    end else if (freeze) begin
      // hold
    end else if (!id_valid) begin
      t = in_b;
      t.cmd = 4'd0; t.mem_read = 1'b0; t.mem_write = 1'b0;
      t.wb_en = 1'b0; t.imm = 1'b0; t.b = 1'b0; t.update = 1'b0;
      exp_b = t;
      exp_valid = 1'b0;
      exp_bub = sat_inc(exp_bub);
    end else begin
      exp_b = in_b;
      exp_valid = 1'b1;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_bundle();
    logic [31:0] r;
    in_b.pc = $urandom();
    in_b.rn = $urandom();
    in_b.rm = $urandom();
    r = $urandom();
    in_b.dst = r[3:0]; in_b.src1 = r[7:4]; in_b.src2 = r[11:8];
    in_b.status = r[15:12]; in_b.cmd = r[19:16];
    in_b.mem_read = r[20]; in_b.mem_write = r[21]; in_b.wb_en = r[22];
    in_b.imm = r[23]; in_b.b = r[24]; in_b.update = r[25];
    r = $urandom();
    in_b.simm = r[23:0];
    r = $urandom();
    in_b.shop = r[11:0];
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    flush = 1'b1;
    freeze = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b1;
    flush = 1'b0;
    freeze = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset: load nonzero contents, then pull reset low mid-cycle.
    id_valid = 1'b1;
    rand_bundle();
    in_b.wb_en = 1'b1;
    step("preload");
    do_reset();

    // Load.
    in_b = '0;
    id_valid = 1'b1;
    in_b.pc = 32'h40;
    in_b.wb_en = 1'b1;
    in_b.cmd = 4'b0010;
    in_b.rn = 32'h1234;
    step("load");
    check("load.pc_lit", 64'(pc_out), 64'h40);
    check("load.valid_lit", 64'(valid_out), 64'd1);

    // Freeze for three cycles with new inputs, then release.
    freeze = 1'b1;
    in_b.pc = 32'h44;
    for (int i = 0; i < 3; i++) step("freeze");
    check("freeze.pc_lit", 64'(pc_out), 64'h40);
    freeze = 1'b0;
    step("unfreeze");
    check("unfreeze.pc_lit", 64'(pc_out), 64'h44);

    // Flush wins over freeze.
    flush = 1'b1;
    freeze = 1'b1;
    in_b.b = 1'b1;
    step("flush_prio");
    check("flush_prio.fl_lit", 64'(flush_cnt), 64'd1);
    check("flush_prio.bub_lit", 64'(bubble_cnt), 64'd1);
    flush = 1'b0;
    freeze = 1'b0;

    // Bubble load.
    id_valid = 1'b0;
    in_b.mem_write = 1'b1;
    in_b.pc = 32'h48;
    step("bubble");
    check("bubble.mw_lit", 64'(mem_write_out), 64'd0);
    check("bubble.bub_lit", 64'(bubble_cnt), 64'd2);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      rand_bundle();
      flush = ($urandom_range(0, 7) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    // Saturation after a fresh reset: 20 consecutive flushes.
    flush = 1'b0;
    freeze = 1'b0;
    do_reset();
    flush = 1'b1;
    id_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_bundle();
      step("sat");
    end
    check("sat.fl_lit", 64'(flush_cnt), 64'd15);
    check("sat.bub_lit", 64'(bubble_cnt), 64'd15);
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
